// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit read-side sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uart_pkg;

  // Width of the baud divisor held in the shadow configuration.
  localparam int UART_DIV_W = 16;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Frame configuration latched at each pop so mid-frame changes cannot
  // corrupt the frame on the wire.
  typedef struct packed {
    logic [UART_DIV_W-1:0] baud_div;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  two_stop;
  } uart_cfg_t;

endpackage

// File: rtl/uart_tx_ctrl_baud_tick.sv
// Bit-time generator: counts 0..D-1 with D = max(div,1) and flags the last clock.
// Latency: tick is combinational from the counter; restart takes effect on the next edge.
// Backpressure: none; free-running between restarts.
// Ports: rclk/rrst clock and sync reset, restart reloads the counter to 0,
//        div clocks per bit, tick high on the last clock of each bit.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_cnt;

  // A divisor of 0 behaves like 1: every clock is a full bit.
  always_comb begin
    last_cnt = (div == '0) ? '0 : div - DIV_W'(1);
  end

  assign tick = (cnt_q == last_cnt);

  // The counter never passes D-1, so it cannot wrap.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops the TX FIFO one word per frame and serialises it onto txd.
// Latency: rinc in cycle N gives the start bit on txd from cycle N+1; back-to-back frames have no gap.
// Backpressure: pops only when idle or in the last stop clock, with tx_en high and the FIFO non-empty.
// Ports: rclk/rrst clock and sync reset; tx_en, baud_div, parity_en, parity_odd,
//        two_stop frame configuration (sampled at pop); rempty/rdata/rinc FIFO read
//        port (show-ahead); txd serial line, busy frame in progress, frame_done
//        pulse on the last clock of the final stop bit.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DSIZE = 8,
  // Must not exceed UART_DIV_W; the shadow register holds UART_DIV_W bits.
  parameter int DIV_W = UART_DIV_W
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  localparam int IDX_W = $clog2(DSIZE + 1);

  tx_state_t        state_q,    state_d;
  logic [DSIZE-1:0] shreg_q,    shreg_d;
  uart_cfg_t        cfg_q,      cfg_d;
  logic             par_q,      par_d;
  logic [IDX_W-1:0] bit_idx_q,  bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic             txd_q,      txd_d;

  logic tick;
  logic last_stop;
  logic frame_end;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .rclk    (rclk),
    .rrst    (rrst),
    .restart (rinc),
    .div     (DIV_W'(cfg_q.baud_div)),
    .tick    (tick)
  );

  // stop_idx counts 0 or 0..1; the final stop bit is the one matching two_stop.
  assign last_stop = (stop_idx_q == cfg_q.two_stop);
  assign frame_end = (state_q == STOP) && tick && last_stop;

  // State register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cfg_q      <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= UART_IDLE_LVL;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cfg_q      <= cfg_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
    end
  end

  // Next-state logic. txd_d is the level of the bit being entered, so the
  // line changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cfg_d      = cfg_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd_q;

    unique case (state_q)
      IDLE: begin
        txd_d = UART_IDLE_LVL;
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          txd_d     = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == IDX_W'(DSIZE - 1)) begin
            bit_idx_d = '0;
            if (cfg_q.parity_en) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
              txd_d      = UART_IDLE_LVL;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            // Next bit to send is the one that lands in bit 0 after the shift.
            txd_d     = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          txd_d      = UART_IDLE_LVL;
        end
      end
      STOP: begin
        if (tick) begin
          if (last_stop) begin
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = UART_IDLE_LVL;
      end
    endcase

    // A pop overrides everything: from IDLE or straight out of the final
    // stop clock into the next start bit.
    if (rinc) begin
      state_d    = START;
      txd_d      = UART_START_LVL;
      shreg_d    = rdata;
      cfg_d.baud_div   = UART_DIV_W'(baud_div);
      cfg_d.parity_en  = parity_en;
      cfg_d.parity_odd = parity_odd;
      cfg_d.two_stop   = two_stop;
      // Parity is fixed by the captured word, so compute it once here.
      par_d      = (^rdata) ^ parity_odd;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    rinc       = !rrst && tx_en && !rempty && ((state_q == IDLE) || frame_end);
    frame_done = !rrst && frame_end;
    busy       = (state_q != IDLE);
    txd        = txd_q;
  end

endmodule
